// File: rtl/mwrite_pkg.sv
// mwrite_pkg: shared types and constants for the memory-write stage.
//   state_t      - FSM state encoding (IDLE / REQ / RESP)
//   STRB_B/H/W   - lane-0-relative byte masks for byte, half and word stores
//   reg_bundle_t - register writeback bundle (valid, destination, data)
package mwrite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } reg_bundle_t;

endpackage

// File: rtl/mwrite_store_align.sv
// mwrite_store_align: combinational lane shift of a lane-0-relative store.
// Ports:
//   strb_in  in  4   lane-0-relative byte mask
//   data_in  in  32  lane-0-relative store data
//   off      in  2   byte offset within the word (ADDR[1:0])
//   strb_out out 4   byte mask shifted into its lanes
//   data_out out 32  data shifted into its lanes
//   misalign out 1   store crosses a word boundary or has an empty mask
module mwrite_store_align (
  input  logic [3:0]  strb_in,
  input  logic [31:0] data_in,
  input  logic [1:0]  off,
  output logic [3:0]  strb_out,
  output logic [31:0] data_out,
  output logic        misalign
);

  // Shift in a 7-bit field so bytes pushed past lane 3 remain visible
  // for the boundary-crossing check.
  logic [6:0] strb_wide;

  always_comb begin
    strb_wide = {3'b000, strb_in} << off;
    strb_out  = strb_wide[3:0];
    data_out  = data_in << {off, 3'b000};
    misalign  = (|strb_wide[6:4]) || (strb_in == 4'b0000);
  end

endmodule

// File: rtl/mwrite.sv
// mwrite: memory-write stage. Captures the register and store bundles from
// mread while idle, issues the store over a valid/ready request channel,
// waits for the write response, and emits a one-cycle register writeback.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | accepting inputs; MEMW_WAIT low
//   REQ   | DMEM_W_VALID high, request held until DMEM_W_READY
//   RESP  | DMEM_B_READY high, waiting for DMEM_B_VALID or timeout
//
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   MEMR_REG_W_VALID/RD/DATA          register write bundle from mread
//   MEMR_MEM_W_VALID/ADDR/STRB/DATA   store bundle from mread (lane-0-relative)
//   MEMW_WAIT                         inputs not accepted while high
//   DMEM_W_VALID/READY/ADDR/STRB/DATA store request channel
//   DMEM_B_VALID/READY                store response channel
//   MEMW_REG_W_VALID/RD/DATA          register-file write port
//   MEMW_ERR_MISALIGN                 pulse: store dropped (boundary / empty mask)
//   MEMW_ERR_TIMEOUT                  pulse: response did not arrive in time
module mwrite
  import mwrite_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEMR_REG_W_VALID,
  input  logic [4:0]  MEMR_REG_W_RD,
  input  logic [31:0] MEMR_REG_W_DATA,
  input  logic        MEMR_MEM_W_VALID,
  input  logic [31:0] MEMR_MEM_W_ADDR,
  input  logic [3:0]  MEMR_MEM_W_STRB,
  input  logic [31:0] MEMR_MEM_W_DATA,
  output logic        MEMW_WAIT,
  output logic        DMEM_W_VALID,
  input  logic        DMEM_W_READY,
  output logic [31:0] DMEM_W_ADDR,
  output logic [3:0]  DMEM_W_STRB,
  output logic [31:0] DMEM_W_DATA,
  input  logic        DMEM_B_VALID,
  output logic        DMEM_B_READY,
  output logic        MEMW_REG_W_VALID,
  output logic [4:0]  MEMW_REG_W_RD,
  output logic [31:0] MEMW_REG_W_DATA,
  output logic        MEMW_ERR_MISALIGN,
  output logic        MEMW_ERR_TIMEOUT
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int TO_M1 = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
  // Counter holds the number of RESP cycles already spent; the timeout
  // fires in the RESP cycle where this reaches TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] TO_LAST = TO_M1[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       data_q, data_d;
  reg_bundle_t       wb_q, wb_d;
  logic              err_mis_q, err_mis_d;
  logic              err_to_q, err_to_d;

  logic [3:0]        al_strb;
  logic [31:0]       al_data;
  logic              al_misalign;

  mwrite_store_align u_align (
    .strb_in  (MEMR_MEM_W_STRB),
    .data_in  (MEMR_MEM_W_DATA),
    .off      (MEMR_MEM_W_ADDR[1:0]),
    .strb_out (al_strb),
    .data_out (al_data),
    .misalign (al_misalign)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      strb_q    <= '0;
      data_q    <= '0;
      wb_q      <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      strb_q    <= strb_d;
      data_q    <= data_d;
      wb_q      <= wb_d;
      err_mis_q <= err_mis_d;
      err_to_q  <= err_to_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    strb_d     = strb_q;
    data_d     = data_q;
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    err_mis_d  = 1'b0;
    err_to_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Register writeback is independent of what happens to the store.
        if (MEMR_REG_W_VALID) begin
          wb_d.valid = 1'b1;
          wb_d.rd    = MEMR_REG_W_RD;
          wb_d.data  = MEMR_REG_W_DATA;
        end
        if (MEMR_MEM_W_VALID) begin
          if (al_misalign) begin
            err_mis_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            addr_d  = {MEMR_MEM_W_ADDR[31:2], 2'b00};
            strb_d  = al_strb;
            data_d  = al_data;
          end
        end
      end
      ST_REQ: begin
        if (DMEM_W_READY) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        if (DMEM_B_VALID) begin
          state_d = ST_IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign MEMW_WAIT         = (state_q != ST_IDLE);
  assign DMEM_W_VALID      = (state_q == ST_REQ);
  assign DMEM_B_READY      = (state_q == ST_RESP);
  assign DMEM_W_ADDR       = addr_q;
  assign DMEM_W_STRB       = strb_q;
  assign DMEM_W_DATA       = data_q;
  assign MEMW_REG_W_VALID  = wb_q.valid;
  assign MEMW_REG_W_RD     = wb_q.rd;
  assign MEMW_REG_W_DATA   = wb_q.data;
  assign MEMW_ERR_MISALIGN = err_mis_q;
  assign MEMW_ERR_TIMEOUT  = err_to_q;

endmodule

// File: tb/tb_mwrite.sv
module tb_mwrite;
  import mwrite_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEMR_REG_W_VALID;
  logic [4:0]  MEMR_REG_W_RD;
  logic [31:0] MEMR_REG_W_DATA;
  logic        MEMR_MEM_W_VALID;
  logic [31:0] MEMR_MEM_W_ADDR;
  logic [3:0]  MEMR_MEM_W_STRB;
  logic [31:0] MEMR_MEM_W_DATA;
  logic        MEMW_WAIT;
  logic        DMEM_W_VALID;
  logic        DMEM_W_READY;
  logic [31:0] DMEM_W_ADDR;
  logic [3:0]  DMEM_W_STRB;
  logic [31:0] DMEM_W_DATA;
  logic        DMEM_B_VALID;
  logic        DMEM_B_READY;
  logic        MEMW_REG_W_VALID;
  logic [4:0]  MEMW_REG_W_RD;
  logic [31:0] MEMW_REG_W_DATA;
  logic        MEMW_ERR_MISALIGN;
  logic        MEMW_ERR_TIMEOUT;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mwrite #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .MEMR_REG_W_VALID  (MEMR_REG_W_VALID),
    .MEMR_REG_W_RD     (MEMR_REG_W_RD),
    .MEMR_REG_W_DATA   (MEMR_REG_W_DATA),
    .MEMR_MEM_W_VALID  (MEMR_MEM_W_VALID),
    .MEMR_MEM_W_ADDR   (MEMR_MEM_W_ADDR),
    .MEMR_MEM_W_STRB   (MEMR_MEM_W_STRB),
    .MEMR_MEM_W_DATA   (MEMR_MEM_W_DATA),
    .MEMW_WAIT         (MEMW_WAIT),
    .DMEM_W_VALID      (DMEM_W_VALID),
    .DMEM_W_READY      (DMEM_W_READY),
    .DMEM_W_ADDR       (DMEM_W_ADDR),
    .DMEM_W_STRB       (DMEM_W_STRB),
    .DMEM_W_DATA       (DMEM_W_DATA),
    .DMEM_B_VALID      (DMEM_B_VALID),
    .DMEM_B_READY      (DMEM_B_READY),
    .MEMW_REG_W_VALID  (MEMW_REG_W_VALID),
    .MEMW_REG_W_RD     (MEMW_REG_W_RD),
    .MEMW_REG_W_DATA   (MEMW_REG_W_DATA),
    .MEMW_ERR_MISALIGN (MEMW_ERR_MISALIGN),
    .MEMW_ERR_TIMEOUT  (MEMW_ERR_TIMEOUT)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    MEMR_REG_W_VALID = 1'b0;
    MEMR_REG_W_RD    = '0;
    MEMR_REG_W_DATA  = '0;
    MEMR_MEM_W_VALID = 1'b0;
    MEMR_MEM_W_ADDR  = '0;
    MEMR_MEM_W_STRB  = '0;
    MEMR_MEM_W_DATA  = '0;
    DMEM_W_READY     = 1'b0;
    DMEM_B_VALID     = 1'b0;
  endtask

  // Issue one store with READY high and an immediate response.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] data, input logic exp_mis,
                          input logic [3:0] exp_strb, input logic [31:0] exp_data);
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = addr;
    MEMR_MEM_W_STRB  = strb;
    MEMR_MEM_W_DATA  = data;
    DMEM_W_READY     = 1'b1;
    tick();
    MEMR_MEM_W_VALID = 1'b0;
    chk({tag, "_mis"},    MEMW_ERR_MISALIGN, exp_mis);
    chk({tag, "_wvalid"}, DMEM_W_VALID, !exp_mis);
    chk({tag, "_wait"},   MEMW_WAIT, !exp_mis);
    if (!exp_mis) begin
      chk({tag, "_addr"}, DMEM_W_ADDR, {addr[31:2], 2'b00});
      chk({tag, "_strb"}, DMEM_W_STRB, exp_strb);
      chk({tag, "_data"}, DMEM_W_DATA, exp_data);
      tick();
      DMEM_B_VALID = 1'b1;
      tick();
      DMEM_B_VALID = 1'b0;
      chk({tag, "_done"}, MEMW_WAIT, 1'b0);
    end else begin
      tick();
      chk({tag, "_mis_end"}, MEMW_ERR_MISALIGN, 1'b0);
      chk({tag, "_no_req"},  DMEM_W_VALID, 1'b0);
    end
    DMEM_W_READY = 1'b0;
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    tick();
    tick();
    chk("rst_wait",   MEMW_WAIT, 1'b0);
    chk("rst_wvalid", DMEM_W_VALID, 1'b0);
    chk("rst_bready", DMEM_B_READY, 1'b0);
    chk("rst_regw",   MEMW_REG_W_VALID, 1'b0);
    chk("rst_addr",   DMEM_W_ADDR, 32'h0);
    chk("rst_errs",   {MEMW_ERR_MISALIGN, MEMW_ERR_TIMEOUT}, 2'b00);
    RST = 1'b0;
    tick();

    // SW 0xDEADBEEF @0x100: WAIT high through REQ + three RESP cycles.
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = 32'h100;
    MEMR_MEM_W_STRB  = STRB_W;
    MEMR_MEM_W_DATA  = 32'hDEADBEEF;
    DMEM_W_READY     = 1'b1;
    tick();
    MEMR_MEM_W_VALID = 1'b0;
    chk("sw_wvalid", DMEM_W_VALID, 1'b1);
    chk("sw_addr",   DMEM_W_ADDR, 32'h100);
    chk("sw_strb",   DMEM_W_STRB, 4'b1111);
    chk("sw_data",   DMEM_W_DATA, 32'hDEADBEEF);
    chk("sw_wait1",  MEMW_WAIT, 1'b1);
    tick();
    DMEM_W_READY = 1'b0;
    chk("sw_wvalid_drop", DMEM_W_VALID, 1'b0);
    chk("sw_bready",      DMEM_B_READY, 1'b1);
    chk("sw_wait2",       MEMW_WAIT, 1'b1);
    tick();
    chk("sw_wait3", MEMW_WAIT, 1'b1);
    tick();
    chk("sw_wait4", MEMW_WAIT, 1'b1);
    DMEM_B_VALID = 1'b1;
    tick();
    DMEM_B_VALID = 1'b0;
    chk("sw_wait_low",  MEMW_WAIT, 1'b0);
    chk("sw_bready_lo", DMEM_B_READY, 1'b0);
    chk("sw_no_regw",   MEMW_REG_W_VALID, 1'b0);

    // Lane-shift and misalignment vectors.
    do_store("sb203",  32'h203, STRB_B, 32'h000000AB, 1'b0, 4'b1000, 32'hAB000000);
    do_store("sw102",  32'h102, STRB_W, 32'h12345678, 1'b1, 4'b0000, 32'h0);
    do_store("sh003",  32'h003, STRB_H, 32'h0000BEEF, 1'b1, 4'b0000, 32'h0);
    do_store("sh002",  32'h002, STRB_H, 32'h0000BEEF, 1'b0, 4'b1100, 32'hBEEF0000);
    do_store("sb001",  32'h001, STRB_B, 32'h00000055, 1'b0, 4'b0010, 32'h00005500);
    do_store("sh001",  32'h001, STRB_H, 32'h00001234, 1'b0, 4'b0110, 32'h00123400);
    do_store("strb0",  32'h040, 4'b0000, 32'hFFFFFFFF, 1'b1, 4'b0000, 32'h0);

    // READY low for 5 cycles; B_VALID while in REQ must be ignored.
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = 32'h300;
    MEMR_MEM_W_STRB  = STRB_W;
    MEMR_MEM_W_DATA  = 32'h11223344;
    tick();
    MEMR_MEM_W_VALID = 1'b0;
    DMEM_B_VALID     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", DMEM_W_VALID, 1'b1);
      chk("stall_addr",  DMEM_W_ADDR, 32'h300);
      chk("stall_data",  DMEM_W_DATA, 32'h11223344);
      tick();
    end
    chk("stall_still_req", DMEM_W_VALID, 1'b1);
    DMEM_B_VALID = 1'b0;
    DMEM_W_READY = 1'b1;
    tick();
    DMEM_W_READY = 1'b0;
    chk("stall_xfer_drop", DMEM_W_VALID, 1'b0);
    chk("stall_resp",      DMEM_B_READY, 1'b1);
    DMEM_B_VALID = 1'b1;
    tick();
    DMEM_B_VALID = 1'b0;
    chk("stall_done", MEMW_WAIT, 1'b0);

    // Timeout: no response for 4 RESP cycles.
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = 32'h400;
    MEMR_MEM_W_STRB  = STRB_W;
    MEMR_MEM_W_DATA  = 32'hA5A5A5A5;
    DMEM_W_READY     = 1'b1;
    tick();
    MEMR_MEM_W_VALID = 1'b0;
    tick();
    DMEM_W_READY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("to_bready", DMEM_B_READY, 1'b1);
      chk("to_no_err", MEMW_ERR_TIMEOUT, 1'b0);
      tick();
    end
    chk("to_pulse", MEMW_ERR_TIMEOUT, 1'b1);
    chk("to_idle",  MEMW_WAIT, 1'b0);
    tick();
    chk("to_pulse_end", MEMW_ERR_TIMEOUT, 1'b0);

    // Reg-only bundle with RD=0 passes straight through.
    MEMR_REG_W_VALID = 1'b1;
    MEMR_REG_W_RD    = 5'd0;
    MEMR_REG_W_DATA  = 32'h0000CAFE;
    tick();
    MEMR_REG_W_VALID = 1'b0;
    chk("rd0_valid", MEMW_REG_W_VALID, 1'b1);
    chk("rd0_rd",    MEMW_REG_W_RD, 5'd0);
    chk("rd0_data",  MEMW_REG_W_DATA, 32'h0000CAFE);
    chk("rd0_wait",  MEMW_WAIT, 1'b0);
    tick();
    chk("rd0_pulse_end", MEMW_REG_W_VALID, 1'b0);

    // x5=0x1234 with SH @0x0; upstream holds bundle while WAIT; then RST in REQ.
    MEMR_REG_W_VALID = 1'b1;
    MEMR_REG_W_RD    = 5'd5;
    MEMR_REG_W_DATA  = 32'h00001234;
    MEMR_MEM_W_VALID = 1'b1;
    MEMR_MEM_W_ADDR  = 32'h0;
    MEMR_MEM_W_STRB  = STRB_H;
    MEMR_MEM_W_DATA  = 32'h0000BEEF;
    tick();
    chk("x5_valid",  MEMW_REG_W_VALID, 1'b1);
    chk("x5_rd",     MEMW_REG_W_RD, 5'd5);
    chk("x5_data",   MEMW_REG_W_DATA, 32'h00001234);
    chk("x5_wvalid", DMEM_W_VALID, 1'b1);
    chk("x5_strb",   DMEM_W_STRB, 4'b0011);
    tick();
    chk("x5_once",   MEMW_REG_W_VALID, 1'b0);
    chk("x5_in_req", DMEM_W_VALID, 1'b1);
    RST = 1'b1;
    tick();
    chk("rst_req_wvalid", DMEM_W_VALID, 1'b0);
    chk("rst_req_wait",   MEMW_WAIT, 1'b0);
    chk("rst_req_regw",   MEMW_REG_W_VALID, 1'b0);
    chk("rst_req_addr",   DMEM_W_ADDR, 32'h0);
    chk("rst_req_strb",   DMEM_W_STRB, 4'b0000);
    chk("rst_req_bready", DMEM_B_READY, 1'b0);
    idle_inputs();
    RST = 1'b0;
    tick();
    chk("post_rst_idle", MEMW_WAIT, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
